// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV64 subset multicycle CPU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state enum, ALU function enum, instruction class enum,
// opcode/funct constants, ALUSrcA/ALUSrcB select constants and the packed
// control-flag bundle driven by control_unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    BRANCH,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LD,
    CLS_SD,
    CLS_BR,
    CLS_ILL
  } instr_class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;  // add, sub, addi
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_D   = 3'b011;  // ld / sd doubleword
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_REGA = 1'b1;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_e    alu_op;
    logic       load_a_out;
    logic       load_reg_a;
    logic       load_reg_b;
    logic       reg_write;
    logic       mem_to_reg;
    logic       dmem_op;
    logic       load_mdr;
    logic       imem_read;
    logic       ir_write;
    logic       halted;
    logic       instr_retired;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Classifies an instruction word and picks the R-type ALU function.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word.
// Ports: instruction (in 32), instr_class (class enum), legal (1 = supported
// encoding), r_alu_op (ALU function for R-type, ADD otherwise).
module instr_decode
  import cpu_pkg::*;
(
  input  logic [31:0]  instruction,
  output instr_class_e instr_class,
  output logic         legal,
  output alu_op_e      r_alu_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Register and immediate fields belong to the datapath.
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    instr_class = CLS_ILL;
    r_alu_op    = ALU_ADD;
    unique case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            F3_ADD: begin instr_class = CLS_R; r_alu_op = ALU_ADD; end
            F3_XOR: begin instr_class = CLS_R; r_alu_op = ALU_XOR; end
            F3_OR:  begin instr_class = CLS_R; r_alu_op = ALU_OR;  end
            F3_AND: begin instr_class = CLS_R; r_alu_op = ALU_AND; end
            default: instr_class = CLS_ILL;
          endcase
        end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          instr_class = CLS_R;
          r_alu_op    = ALU_SUB;
        end
      end
      OPC_IMM:    if (funct3 == F3_ADD) instr_class = CLS_I;
      OPC_LOAD:   if (funct3 == F3_D)   instr_class = CLS_LD;
      OPC_STORE:  if (funct3 == F3_D)   instr_class = CLS_SD;
      OPC_BRANCH: if (funct3 == F3_BEQ) instr_class = CLS_BR;
      default:    instr_class = CLS_ILL;
    endcase
  end

  assign legal = (instr_class != CLS_ILL);

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM driving the RV64 subset datapath flags.
// Latency: fetch 1+MEM_WAIT cycles, then 2..4 more per class (ld adds MEM_WAIT).
// Backpressure: none; memory latency is the fixed MEM_WAIT, halts on illegal ops.
// Ports: clk, reset (async active-low), instruction (IR contents); PC, ALU,
// register, memory and IR control flags out; halted (sticky); instr_retired.
module control_unit
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        LoadAOut,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        halted,
  output logic        instr_retired
);

  localparam logic [2:0] WAIT_LAST = MEM_WAIT[2:0];

  state_e       state, state_nxt;
  logic [2:0]   wait_cnt, wait_cnt_nxt;
  instr_class_e instr_class;
  logic         legal;
  alu_op_e      r_alu_op;
  ctrl_t        ctrl;
  logic         wait_done;

  instr_decode u_instr_decode (
    .instruction (instruction),
    .instr_class (instr_class),
    .legal       (legal),
    .r_alu_op    (r_alu_op)
  );

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:     if (wait_done) state_nxt = DECODE;
      DECODE: begin
        if (!legal) begin
          state_nxt = HALT;
        end else begin
          unique case (instr_class)
            CLS_R:          state_nxt = EXEC_R;
            CLS_I:          state_nxt = EXEC_I;
            CLS_LD, CLS_SD: state_nxt = MEM_ADDR;
            CLS_BR:         state_nxt = BRANCH;
            default:        state_nxt = HALT;
          endcase
        end
      end
      EXEC_R:    state_nxt = ALU_WB;
      EXEC_I:    state_nxt = ALU_WB;
      ALU_WB:    state_nxt = FETCH;
      MEM_ADDR:  state_nxt = (instr_class == CLS_LD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (wait_done) state_nxt = MEM_WB;
      MEM_WB:    state_nxt = FETCH;
      MEM_WRITE: state_nxt = FETCH;
      BRANCH:    state_nxt = FETCH;
      HALT:      state_nxt = HALT;
      default:   state_nxt = HALT;
    endcase

    // Counter restarts at every state change; the exit test is equality with
    // MEM_WAIT, so it never needs to wrap.
    if (state_nxt != state) begin
      wait_cnt_nxt = 3'd0;
    end else if (state == FETCH || state == MEM_READ) begin
      wait_cnt_nxt = wait_cnt + 3'd1;
    end else begin
      wait_cnt_nxt = wait_cnt;
    end
  end

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.imem_read = 1'b1;
        if (wait_done) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_a = SRCA_PC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = 1'b0;
        end
      end
      DECODE: begin
        // Precompute the branch target into AOut while operands load.
        ctrl.load_reg_a = 1'b1;
        ctrl.load_reg_b = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_IMM2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.load_a_out = 1'b1;
      end
      EXEC_R: begin
        ctrl.alu_src_a  = SRCA_REGA;
        ctrl.alu_src_b  = SRCB_REGB;
        ctrl.alu_op     = r_alu_op;
        ctrl.load_a_out = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        ctrl.alu_src_a  = SRCA_REGA;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALU_ADD;
        ctrl.load_a_out = 1'b1;
      end
      ALU_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.instr_retired = 1'b1;
      end
      MEM_READ: ctrl.load_mdr = wait_done;
      MEM_WB: begin
        ctrl.reg_write     = 1'b1;
        ctrl.mem_to_reg    = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.dmem_op       = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_retired = 1'b1;
      end
      HALT:    ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Reset gates every flag combinationally so an in-flight write strobe
  // drops the instant reset asserts, and FETCH stays silent while held.
  assign PCWrite       = reset & ctrl.pc_write;
  assign PCWriteCond   = reset & ctrl.pc_write_cond;
  assign PCSource      = reset & ctrl.pc_source;
  assign ALUSrcA       = reset & ctrl.alu_src_a;
  assign ALUSrcB       = reset ? ctrl.alu_src_b : 2'd0;
  assign ALUOp         = reset ? ctrl.alu_op : 3'd0;
  assign LoadAOut      = reset & ctrl.load_a_out;
  assign LoadRegA      = reset & ctrl.load_reg_a;
  assign LoadRegB      = reset & ctrl.load_reg_b;
  assign RegWrite      = reset & ctrl.reg_write;
  assign MemToReg      = reset & ctrl.mem_to_reg;
  assign DMemOp        = reset & ctrl.dmem_op;
  assign LoadMDR       = reset & ctrl.load_mdr;
  assign IMemRead      = reset & ctrl.imem_read;
  assign IRWrite       = reset & ctrl.ir_write;
  assign halted        = reset & ctrl.halted;
  assign instr_retired = reset & ctrl.instr_retired;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected flag vectors are
// queued when an instruction is applied and compared on the falling edge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr0, instr1;

  // Flag vector bit layout used for every comparison.
  localparam logic [19:0] B_PCW  = 20'h80000;
  localparam logic [19:0] B_PCC  = 20'h40000;
  localparam logic [19:0] B_PCS  = 20'h20000;
  localparam logic [19:0] B_ASA  = 20'h10000;
  localparam logic [19:0] B_LAO  = 20'h00400;
  localparam logic [19:0] B_LRA  = 20'h00200;
  localparam logic [19:0] B_LRB  = 20'h00100;
  localparam logic [19:0] B_RW   = 20'h00080;
  localparam logic [19:0] B_M2R  = 20'h00040;
  localparam logic [19:0] B_DMO  = 20'h00020;
  localparam logic [19:0] B_LMDR = 20'h00010;
  localparam logic [19:0] B_IMR  = 20'h00008;
  localparam logic [19:0] B_IRW  = 20'h00004;
  localparam logic [19:0] B_HLT  = 20'h00002;
  localparam logic [19:0] B_RET  = 20'h00001;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_SD = 3, C_BR = 4, C_ILL = 5;

  logic        pcw [2], pcc [2], pcs [2], asa [2];
  logic [1:0]  asb [2];
  logic [2:0]  aop [2];
  logic        lao [2], lra [2], lrb [2], rw [2], m2r [2], dmo [2];
  logic        lmdr [2], imr [2], irw [2], hlt [2], ret [2];
  logic [19:0] obs [2];

  control_unit #(.MEM_WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .instruction(instr0),
    .PCWrite(pcw[0]), .PCWriteCond(pcc[0]), .PCSource(pcs[0]),
    .ALUSrcA(asa[0]), .ALUSrcB(asb[0]), .ALUOp(aop[0]),
    .LoadAOut(lao[0]), .LoadRegA(lra[0]), .LoadRegB(lrb[0]),
    .RegWrite(rw[0]), .MemToReg(m2r[0]), .DMemOp(dmo[0]),
    .LoadMDR(lmdr[0]), .IMemRead(imr[0]), .IRWrite(irw[0]),
    .halted(hlt[0]), .instr_retired(ret[0])
  );

  control_unit #(.MEM_WAIT(2)) u_w2 (
    .clk(clk), .reset(reset), .instruction(instr1),
    .PCWrite(pcw[1]), .PCWriteCond(pcc[1]), .PCSource(pcs[1]),
    .ALUSrcA(asa[1]), .ALUSrcB(asb[1]), .ALUOp(aop[1]),
    .LoadAOut(lao[1]), .LoadRegA(lra[1]), .LoadRegB(lrb[1]),
    .RegWrite(rw[1]), .MemToReg(m2r[1]), .DMemOp(dmo[1]),
    .LoadMDR(lmdr[1]), .IMemRead(imr[1]), .IRWrite(irw[1]),
    .halted(hlt[1]), .instr_retired(ret[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign obs[g] = {pcw[g], pcc[g], pcs[g], asa[g], asb[g], aop[g],
                     lao[g], lra[g], lrb[g], rw[g], m2r[g], dmo[g],
                     lmdr[g], imr[g], irw[g], hlt[g], ret[g]};
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] exp_q [$];

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] f_srcb(input int v);
    logic [19:0] r;
    r = 20'(v) << 14;
    return r;
  endfunction

  function automatic logic [19:0] f_aop(input logic [2:0] v);
    logic [19:0] r;
    r = {17'd0, v} << 11;
    return r;
  endfunction

  // Expected flag sequence of one instruction, from the state/output table.
  task automatic push_instr(input int w, input int cls, input logic [2:0] rop, input int halt_cycles);
    for (int i = 0; i < w; i++) exp_q.push_back(B_IMR);
    exp_q.push_back(B_IMR | B_IRW | B_PCW | f_srcb(1) | f_aop(3'b001));
    exp_q.push_back(B_LRA | B_LRB | f_srcb(3) | f_aop(3'b001) | B_LAO);
    case (cls)
      C_R: begin
        exp_q.push_back(B_ASA | f_aop(rop) | B_LAO);
        exp_q.push_back(B_RW | B_RET);
      end
      C_I: begin
        exp_q.push_back(B_ASA | f_srcb(2) | f_aop(3'b001) | B_LAO);
        exp_q.push_back(B_RW | B_RET);
      end
      C_LD: begin
        exp_q.push_back(B_ASA | f_srcb(2) | f_aop(3'b001) | B_LAO);
        for (int i = 0; i < w; i++) exp_q.push_back(20'd0);
        exp_q.push_back(B_LMDR);
        exp_q.push_back(B_RW | B_M2R | B_RET);
      end
      C_SD: begin
        exp_q.push_back(B_ASA | f_srcb(2) | f_aop(3'b001) | B_LAO);
        exp_q.push_back(B_DMO | B_RET);
      end
      C_BR: exp_q.push_back(B_PCC | B_PCS | B_ASA | f_aop(3'b010) | B_RET);
      default: for (int i = 0; i < halt_cycles; i++) exp_q.push_back(B_HLT);
    endcase
  endtask

  task automatic drain(input int d, input string name);
    int c = 1;
    logic [19:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check_val($sformatf("%s.cyc%0d", name, c), obs[d], e);
      c++;
    end
  endtask

  // Reset asserted between clock edges; flags must vanish at once.
  task automatic pulse_reset(input string name);
    #2 reset = 1'b0;
    #1 check_val({name, ".rst_w0"}, obs[0], 20'd0);
    check_val({name, ".rst_w2"}, obs[1], 20'd0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  logic [31:0] t_ins [9];
  int          t_cls [9];
  logic [2:0]  t_op  [9];
  logic [31:0] t_ill [4];

  initial begin
    t_ins = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3,
              32'h00508093, 32'h0080B283, 32'h0020B023, 32'h00208063};
    t_cls = '{C_R, C_R, C_R, C_R, C_R, C_I, C_LD, C_SD, C_BR};
    t_op  = '{3'b001, 3'b010, 3'b101, 3'b100, 3'b011, 3'b001, 3'b001, 3'b001, 3'b001};
    t_ill = '{32'h0020D1B3, 32'h0000A283, 32'h4020C1B3, 32'h00209063};

    reset  = 1'b0;
    instr0 = 32'd0;
    instr1 = 32'd0;
    repeat (2) @(posedge clk);
    #1 check_val("reset_w0", obs[0], 20'd0);
    check_val("reset_w2", obs[1], 20'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // MEM_WAIT=0: every legal instruction back to back.
    for (int i = 0; i < 9; i++) begin
      instr0 = t_ins[i];
      push_instr(0, t_cls[i], t_op[i], 0);
      drain(0, $sformatf("w0_%08h", t_ins[i]));
    end

    // All-zero word halts and stays halted.
    instr0 = 32'd0;
    push_instr(0, C_ILL, 3'b000, 22);
    drain(0, "w0_halt_zero");
    pulse_reset("halt_zero");
    instr0 = t_ins[0];
    push_instr(0, C_R, 3'b001, 0);
    drain(0, "w0_after_halt");

    // Near-miss encodings of legal instructions.
    for (int i = 0; i < 4; i++) begin
      instr0 = t_ill[i];
      push_instr(0, C_ILL, 3'b000, 3);
      drain(0, $sformatf("w0_ill_%08h", t_ill[i]));
      pulse_reset($sformatf("ill%0d", i));
    end

    // MEM_WAIT=2 instance, starting from a fresh reset.
    pulse_reset("to_w2");
    for (int i = 0; i < 9; i++) begin
      instr1 = t_ins[i];
      push_instr(2, t_cls[i], t_op[i], 0);
      drain(1, $sformatf("w2_%08h", t_ins[i]));
    end

    // Reset while ld sits in MEM_WB: RegWrite drops, restart with counter 0.
    instr1 = 32'h0080B283;
    push_instr(2, C_LD, 3'b001, 0);
    drain(1, "w2_ld_mid");
    #1 reset = 1'b0;
    #1 check_val("mid_wb_rst", obs[1], 20'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    instr1 = 32'h002081B3;
    push_instr(2, C_R, 3'b001, 0);
    drain(1, "w2_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the RV64 subset datapath (`processing`). It takes the latched instruction word from the datapath's instruction register and drives every datapath control flag, one Moore state per cycle. The subset is add, sub, and, or, xor, addi, ld, sd and beq. It sits beside `processing` in the CPU top level and forms the other half of the control-flag interface.

## Interface
Parameters:
- `MEM_WAIT`, default 0: extra wait cycles before read data is valid, for instruction fetch and `ld`. Legal range 0..7.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `instruction` in 32: instruction-register contents (`instruction_out` of `processing`).
- `PCWrite`, `PCWriteCond`, `PCSource` out 1 each: PC control.
- `ALUSrcA` out 1: 0 = PC, 1 = reg A.
- `ALUSrcB` out 2: 0 = reg B, 1 = const 4, 2 = imm, 3 = imm*2.
- `ALUOp` out 3: ALU function (`alu_op_e`).
- `LoadAOut`, `LoadRegA`, `LoadRegB`, `RegWrite`, `MemToReg` out 1 each.
- `DMemOp` out 1: data-memory write strobe.
- `LoadMDR` out 1: load the memory data register.
- `IMemRead` out 1: instruction memory read.
- `IRWrite` out 1: load the instruction register.
- `halted` out 1: sticky, set on an illegal instruction.
- `instr_retired` out 1: one-cycle pulse in the final state of each instruction.

## Operation
- Decode fields:
  - opcode = `instruction[6:0]`, funct3 = `[14:12]`, funct7 = `[31:25]`.
  - Legal encodings:
    - R-type 0110011: add (f3 000, f7 0000000), sub (000, 0100000), xor (100, 0), or (110, 0), and (111, 0).
    - addi: 0010011 / 000.
    - ld: 0000011 / 011.
    - sd: 0100011 / 011.
    - beq: 1100011 / 000.
  - Anything else, including all zeros, is illegal.
- Outputs not listed for a state are 0.
- States and outputs:
  - FETCH: `IMemRead`=1.
    - Stays in FETCH while the wait counter is below `MEM_WAIT`.
    - On the final cycle also asserts `IRWrite`, `PCWrite`, `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=ADD, `PCSource`=0, then moves to DECODE.
  - DECODE: `LoadRegA`, `LoadRegB`, `ALUSrcA`=0, `ALUSrcB`=3, `ALUOp`=ADD, `LoadAOut` (branch target).
    - Next state: EXEC_R, EXEC_I, MEM_ADDR (ld/sd), BRANCH, or HALT if illegal.
  - EXEC_R: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp` from funct3/funct7, `LoadAOut` -> ALU_WB.
  - EXEC_I: `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=ADD, `LoadAOut` -> ALU_WB.
  - ALU_WB: `RegWrite`, `MemToReg`=0, `instr_retired` -> FETCH.
  - MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=ADD, `LoadAOut` -> MEM_READ (ld) or MEM_WRITE (sd).
  - MEM_READ: holds for `MEM_WAIT`+1 cycles, asserting `LoadMDR` on the final cycle -> MEM_WB.
  - MEM_WB: `RegWrite`, `MemToReg`=1, `instr_retired` -> FETCH.
  - MEM_WRITE: `DMemOp` for exactly one cycle, `instr_retired` -> FETCH.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=SUB, `PCWriteCond`, `PCSource`=1, `instr_retired` -> FETCH.
  - HALT: all flags 0 and `halted`=1. Left only by reset.
- `ALUOp` encoding: ADD 3'b001, SUB 3'b010, AND 3'b011, OR 3'b100, XOR 3'b101.

## Timing
- Outputs are Moore: decoded from the state register and wait counter only, except `ALUOp` in EXEC_R, which also depends on `instruction`. `instruction` is stable from DECODE onward.
- Cycles per instruction, with W = `MEM_WAIT`:
  - R-type and addi: 4+W.
  - ld: 5+2W.
  - sd: 4+W.
  - beq: 3+W.
- Wait counter:
  - 3 bits, cleared on every state change.
  - Increments only in FETCH and MEM_READ.
  - Never wraps: the exit condition is counter == `MEM_WAIT`.
- Reset (`reset` low):
  - Takes effect immediately. State goes to FETCH, the counter to 0 and `halted` to 0.
  - All outputs are forced to 0 while reset is held, including `IMemRead`.
  - The first FETCH outputs appear in the cycle after `reset` rises.
- Reset mid-instruction: any in-flight `RegWrite`, `DMemOp` or `PCWrite` drops in the same instant it is asserted. There is no partial retirement.
- Each write strobe (`RegWrite`, `DMemOp`, `PCWrite`, `IRWrite`) is high for at most one cycle per instruction.

## Structure
- `cpu_pkg`, shared with the datapath and the benches, holds:
  - `state_e` enum.
  - `alu_op_e`.
  - opcode, funct3 and funct7 constants.
  - `ALUSrcB` select constants.
- One sub-module, `instr_decode`: combinational. Maps `instruction` to an instruction-class enum, a `legal` flag and the R-type `alu_op_e`.
- `control_unit` contains the state register, the wait counter, the next-state logic and the output decode.

## Test plan
- `MEM_WAIT`=0, add x3,x1,x2 (0x002081B3):
  - States FETCH, DECODE, EXEC_R, ALU_WB.
  - `RegWrite`=1 in cycle 4 only.
  - `ALUOp`=3'b001 in EXEC_R.
- `MEM_WAIT`=2, ld x5,8(x1) (0x0080B283):
  - `IMemRead` high for 3 cycles, `IRWrite` only in the 3rd.
  - `LoadMDR` in the 3rd MEM_READ cycle.
  - `MemToReg`=1 and `RegWrite`=1 in cycle 9.
  - `instr_retired` pulses once.
- sd x2,0(x1) (0x0020B023), `MEM_WAIT`=0: `DMemOp` high exactly 1 cycle, in cycle 4; `RegWrite` never asserted.
- beq x1,x2 (0x00208063), `MEM_WAIT`=0:
  - 3 cycles total.
  - BRANCH shows `PCWriteCond`=1, `PCSource`=1, `ALUOp`=3'b010, `PCWrite`=0.
- Illegal word 0x00000000: DECODE -> HALT, `halted`=1 and all flags 0 for 20+ cycles. Pulsing `reset` low clears `halted` and restarts in FETCH.
- Reset asserted asynchronously mid-MEM_WB (between clock edges): `RegWrite` falls immediately; after release, FETCH with the counter at 0.
